ifetch_unit: RTL and testbench

Instruction fetch sequencer sitting between the program counter and instruction memory. It reads the current PC value, issues one word read per instruction over a request/acknowledge memory port, and holds the returned word for decode. It drives the PC's 2-bit PS control so the PC advances only when decode has consumed the current instruction; otherwise PS is forced to hold. Misaligned PCs raise a sticky fault.

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: samples the PC, fetches one word over a req/ack port,
// holds it for decode and drives the PC step control only on the handoff cycle.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET_VALUE = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [1:0]  ps_req,
  output logic [1:0]  ps,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [31:0] r_fetch_count;
  logic        w_handoff;

  // Decode takes the instruction this cycle; the PC steps on the same edge.
  assign w_handoff = (r_state == S_HOLD) && inst_ready;
  assign ps        = w_handoff ? ps_req : 2'b00;

  // NOTE: every register here uses non-blocking assignment so all state advances
  // together on the edge, and the asynchronous reset clears it without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_inst        <= 32'h0;
      r_inst_valid  <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_addr  <= PC_RESET_VALUE;
      r_fetch_count <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pc[1:0] != 2'b00) begin
            r_fault_addr <= pc;
            r_fault      <= 1'b1;
            r_state      <= S_FAULT;
          end else begin
            r_mem_addr <= pc;
            r_mem_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // A response cannot belong to this request yet, so rvalid is not looked at.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_inst       <= mem_rdata;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_inst_valid  <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_state       <= S_IDLE;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a PC register and memory responder around the DUT,
// compared against a transaction-level model of fetch address, data, count and latency.
module tb_ifetch_unit;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [1:0]  ps_req;
  logic [1:0]  ps;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // Reference model state: where the next fetch must go, what decode last saw, how many.
  logic [31:0] model_pc;
  logic [31:0] last_inst;
  logic [31:0] model_count;

  ifetch_unit #(.PC_RESET_VALUE(PC_RST)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .ps_req      (ps_req),
    .ps          (ps),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [1:0] sel,
                                          input logic [31:0] arg);
    case (sel)
      2'b01:   return cur + 32'd4;
      2'b10:   return cur + arg;
      2'b11:   return arg;
      default: return cur;
    endcase
  endfunction

  // One complete fetch, entered at the negedge of an IDLE cycle and left 1ns after the
  // negedge of the following IDLE cycle. Delays are extra wait cycles on each handshake.
  task automatic fetch(input int ack_dly, input int rv_dly, input int rdy_dly,
                       input logic [1:0] ps_v, input logic [31:0] arg,
                       input logic [31:0] data, input int spur_at);
    int t0;
    logic [1:0] ps_seen;
    ps_seen    = 2'b00;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    inst_ready = 1'b0;
    ps_req     = ps_v;
    #1;
    t0 = cyc_cnt;
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_ps", 32'(ps), 32'd0);
    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clock);
      mem_ack    = (i == ack_dly);
      mem_rvalid = (i == spur_at) && (i < ack_dly);
      mem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("req_req", 32'(mem_req), 32'd1);
      chk("req_addr", mem_addr, model_pc);
      chk("req_inst", inst, last_inst);
      chk("req_valid", 32'(inst_valid), 32'd0);
    end
    for (int i = 0; i <= rv_dly; i++) begin
      @(negedge clock);
      mem_ack    = 1'b0;
      mem_rvalid = (i == rv_dly);
      mem_rdata  = (i == rv_dly) ? data : $urandom;
      #1;
      chk("wait_req", 32'(mem_req), 32'd0);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      chk("wait_inst", inst, last_inst);
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clock);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      inst_ready = (i == rdy_dly);
      #1;
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, data);
      chk("hold_ps", 32'(ps), (i == rdy_dly) ? 32'(ps_v) : 32'd0);
      chk("hold_count", fetch_count, model_count);
      ps_seen = ps;
    end
    chk("fetch_cycles", 32'(cyc_cnt - t0 + 1), 32'(4 + ack_dly + rv_dly + rdy_dly));
    model_count = model_count + 32'd1;
    last_inst   = data;
    model_pc    = next_pc(model_pc, ps_v, arg);
    @(negedge clock);
    inst_ready = 1'b0;
    // The PC register reacts to what the DUT actually drove on the handoff edge.
    pc = next_pc(pc, ps_seen, arg);
    #1;
    chk("after_count", fetch_count, model_count);
    chk("after_valid", 32'(inst_valid), 32'd0);
    chk("after_inst", inst, last_inst);
  endtask

  task automatic chk_reset_values();
    chk("rst_ps", 32'(ps), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_addr", fault_addr, PC_RST);
    chk("rst_fetch_count", fetch_count, 32'd0);
  endtask

  initial begin
    logic [1:0]  r_sel;
    logic [31:0] r_arg;
    reset       = 1'b1;
    pc          = PC_RST;
    ps_req      = 2'b00;
    mem_ack     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    inst_ready  = 1'b0;
    model_pc    = PC_RST;
    last_inst   = 32'h0;
    model_count = 32'h0;

    // Reset values appear before any clock edge.
    #1;
    chk_reset_values();
    @(negedge clock);
    reset = 1'b0;

    // Minimum-latency fetch of a NOP.
    fetch(0, 0, 0, 2'b01, 32'h0, 32'h0000_0013, -1);
    // Backpressure: 3 ack stalls then 5 ready stalls -> 12 cycles.
    fetch(3, 0, 5, 2'b01, 32'h0, 32'h1234_5678, 1);
    // Redirect by absolute jump, then a hold that refetches the same address.
    fetch(0, 0, 0, 2'b11, 32'h8000_0100, 32'hA5A5_0001, -1);
    fetch(0, 0, 0, 2'b00, 32'h0, 32'hA5A5_0002, -1);
    fetch(0, 0, 0, 2'b10, 32'hFFFF_FFF0, 32'hA5A5_0003, -1);
    fetch(1, 2, 1, 2'b01, 32'h0, 32'hA5A5_0004, 0);

    // Reset asserted while waiting for read data abandons the fetch.
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    chk("mid_wait_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_values();
    @(negedge clock);
    reset       = 1'b0;
    model_count = 32'h0;
    last_inst   = 32'h0;
    // The late response arrives two cycles after release, while the new request is pending.
    fetch(2, 0, 0, 2'b01, 32'h0, 32'h0BAD_F00D, 1);

    // Randomized fetches with random handshake delays and PC control.
    for (int n = 0; n < 24; n++) begin
      r_sel = 2'($urandom_range(0, 3));
      if (r_sel == 2'b11) r_arg = 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2);
      else                r_arg = (32'($urandom_range(0, 63)) - 32'd32) << 2;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r_sel, r_arg,
            $urandom, $urandom_range(0, 3));
    end

    // Jump to a misaligned target: the next IDLE faults and nothing else happens.
    fetch(0, 0, 0, 2'b11, 32'h8000_0002, 32'h7777_0000, -1);
    inst_ready = 1'b1;
    ps_req     = 2'b01;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      chk("flt_fault", 32'(fault), 32'd1);
      chk("flt_addr", fault_addr, 32'h8000_0002);
      chk("flt_req", 32'(mem_req), 32'd0);
      chk("flt_valid", 32'(inst_valid), 32'd0);
      chk("flt_ps", 32'(ps), 32'd0);
    end
    mem_rvalid = 1'b0;
    inst_ready = 1'b0;
    reset      = 1'b1;
    #1;
    chk_reset_values();
    pc          = PC_RST;
    model_pc    = PC_RST;
    model_count = 32'h0;
    last_inst   = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    fetch(1, 1, 0, 2'b01, 32'h0, 32'h0000_0093, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
